tuple_bits5_bit_fifo: RTL and testbench

// - Downstream consumer of the Tuple(Bits[5], Bit) stage. Accepts the flattened tuple (I__0 payload, I__1 flag).
// - Packs it LSB-first into a 6-bit word {I__1, I__0}, matching the stage's internal wire x.
// - Buffers words in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
// - Unpacks on the way out to O__0 = word[4:0], O__1 = word[5].

---
 rtl/tuple_bits5_bit_fifo.sv | 88 ++++++++
 tb/tb_tuple_bits5_bit_fifo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/tuple_bits5_bit_fifo.sv
// Small FIFO for the flattened Tuple(Bits[5], Bit): packs {I__1, I__0} into a 6-bit word.
// Optional high-water mark output is enabled by defining TUPLE_FIFO_HWM_EN.
module tuple_bits5_bit_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          CLK,
  input  logic          ASYNCRESET,
  input  logic [4:0]    I__0,
  input  logic          I__1,
  input  logic          I_valid,
  output logic          I_ready,
  output logic [4:0]    O__0,
  output logic          O__1,
  output logic          O_valid,
  input  logic          O_ready,
`ifdef TUPLE_FIFO_HWM_EN
  output logic [AW:0]   hwm,
`endif
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [5:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic [5:0]    head_word;
  logic          push;
  logic          pop;

  // Flags come only from the registered count, so a pop while full
  // cannot re-open I_ready until the following cycle.
  assign I_ready = (count_reg != DEPTH_C);
  assign O_valid = (count_reg != '0);
  assign push    = I_valid & I_ready;
  assign pop     = O_valid & O_ready;
  assign count   = count_reg;

  assign head_word = mem[rd_ptr_reg];
  assign O__0      = O_valid ? head_word[4:0] : 5'd0;
  assign O__1      = O_valid ? head_word[5]   : 1'b0;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage carries no reset; contents are qualified by count.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_reg] <= {I__1, I__0};
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

`ifdef TUPLE_FIFO_HWM_EN
  logic [AW:0] hwm_reg;

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      hwm_reg <= '0;
    end else if (count_next > hwm_reg) begin
      hwm_reg <= count_next;
    end
  end

  assign hwm = hwm_reg;
`endif

endmodule

// File: tb/tb_tuple_bits5_bit_fifo.sv
// Scoreboard bench for tuple_bits5_bit_fifo: directed corner cases plus random traffic.
// A negedge reference model tracks occupancy; a separate monitor checks head words.
module tb_tuple_bits5_bit_fifo;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          CLK = 1'b0;
  logic          ASYNCRESET = 1'b1;
  logic [4:0]    I__0 = '0;
  logic          I__1 = 1'b0;
  logic          I_valid = 1'b0;
  logic          I_ready;
  logic [4:0]    O__0;
  logic          O__1;
  logic          O_valid;
  logic          O_ready = 1'b0;
  logic [AW:0]   count;
`ifdef TUPLE_FIFO_HWM_EN
  logic [AW:0]   hwm;
`endif

  int total = 0;
  int bad   = 0;
  logic [5:0] sb_q [$];
  int model_cnt = 0;
  int model_hwm = 0;

  tuple_bits5_bit_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK),
    .ASYNCRESET(ASYNCRESET),
    .I__0(I__0),
    .I__1(I__1),
    .I_valid(I_valid),
    .I_ready(I_ready),
    .O__0(O__0),
    .O__1(O__1),
    .O_valid(O_valid),
    .O_ready(O_ready),
`ifdef TUPLE_FIFO_HWM_EN
    .hwm(hwm),
`endif
    .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: a FIFO is just an occupancy number and an ordered queue.
  always @(negedge CLK) begin
    bit push;
    bit pop;
    if (ASYNCRESET) begin
      model_cnt = 0;
      model_hwm = 0;
      sb_q.delete();
    end else begin
      push = I_valid && (model_cnt < DEPTH);
      pop  = O_ready && (model_cnt > 0);
      check("count", int'(count), model_cnt);
      check("i_ready", int'(I_ready), int'(model_cnt < DEPTH));
      check("o_valid", int'(O_valid), int'(model_cnt > 0));
`ifdef TUPLE_FIFO_HWM_EN
      check("hwm", int'(hwm), model_hwm);
`endif
      if (push) sb_q.push_back({I__1, I__0});
      model_cnt = model_cnt + int'(push) - int'(pop);
      if (model_cnt > model_hwm) model_hwm = model_cnt;
    end
  end

  // Monitor: compares every word the DUT hands downstream.
  always @(negedge CLK) begin
    logic [5:0] exp_word;
    if (!ASYNCRESET) begin
      if (O_valid && O_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL head_underflow: got word %0h expected no word", {O__1, O__0});
        end else begin
          exp_word = sb_q.pop_front();
          check("head_word", int'({O__1, O__0}), int'(exp_word));
        end
      end else if (!O_valid) begin
        check("empty_mask", int'({O__1, O__0}), 0);
      end
    end
  end

  initial begin
    // Power-on reset
    step();
    step();
    ASYNCRESET = 1'b0;
    check("rst_count", int'(count), 0);
    check("rst_o_valid", int'(O_valid), 0);
    check("rst_i_ready", int'(I_ready), 1);
    check("rst_o_data", int'({O__1, O__0}), 0);

    // Mid-cycle asynchronous reset with two words stored
    I_valid = 1'b1; I__0 = 5'h0a; I__1 = 1'b1;
    step();
    I__0 = 5'h0b; I__1 = 1'b0;
    step();
    I_valid = 1'b0;
    check("pre_rst_count", int'(count), 2);
    #2;
    ASYNCRESET = 1'b1;
    #1;
    check("async_count", int'(count), 0);
    check("async_o_valid", int'(O_valid), 0);
    check("async_i_ready", int'(I_ready), 1);
    check("async_o0", int'(O__0), 0);
    step();
    ASYNCRESET = 1'b0;

    // Single word, latency 1
    I_valid = 1'b1; I__0 = 5'h15; I__1 = 1'b1; O_ready = 1'b0;
    check("single_not_fallthrough", int'(O_valid), 0);
    step();
    I_valid = 1'b0;
    check("single_o_valid", int'(O_valid), 1);
    check("single_o0", int'(O__0), 'h15);
    check("single_o1", int'(O__1), 1);
    check("single_count", int'(count), 1);
    O_ready = 1'b1;
    step();
    O_ready = 1'b0;
    check("single_drained", int'(count), 0);

    // Fill to full, then drain in order
    for (int i = 1; i <= DEPTH; i++) begin
      I_valid = 1'b1; I__0 = 5'(i); I__1 = ((i % 2) == 0);
      step();
    end
    I_valid = 1'b0;
    check("fill_i_ready", int'(I_ready), 0);
    check("fill_count", int'(count), 4);
    O_ready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      check("drain_o0", int'(O__0), i);
      check("drain_o1", int'(O__1), int'((i % 2) == 0));
      step();
    end
    O_ready = 1'b0;

    // Full + simultaneous pop: no push, I_ready reopens one cycle later
    for (int i = 0; i < DEPTH; i++) begin
      I_valid = 1'b1; I__0 = 5'(i + 8); I__1 = i[0];
      step();
    end
    I__0 = 5'h1f; I__1 = 1'b1; O_ready = 1'b1;
    check("fullpop_i_ready_before", int'(I_ready), 0);
    step();
    I_valid = 1'b0;
    check("fullpop_count", int'(count), 3);
    check("fullpop_i_ready_after", int'(I_ready), 1);
    repeat (3) step();
    O_ready = 1'b0;
    check("fullpop_empty", int'(count), 0);

    // Streaming at occupancy 2 across pointer wraps
    for (int i = 0; i < 2; i++) begin
      I_valid = 1'b1; I__0 = 5'(i); I__1 = 1'b0;
      step();
    end
    O_ready = 1'b1;
    for (int i = 2; i < 12; i++) begin
      I__0 = 5'(i); I__1 = i[0];
      step();
      check("stream_count", int'(count), 2);
    end
    I_valid = 1'b0;
    repeat (3) step();
    O_ready = 1'b0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      I_valid = 1'($urandom_range(0, 1));
      O_ready = ($urandom_range(0, 3) != 0);
      I__0 = 5'($urandom);
      I__1 = 1'($urandom);
      step();
    end
    I_valid = 1'b0;
    O_ready = 1'b1;
    repeat (DEPTH + 1) step();
    O_ready = 1'b0;
    check("random_drained", int'(count), 0);

`ifdef TUPLE_FIFO_HWM_EN
    ASYNCRESET = 1'b1;
    step();
    ASYNCRESET = 1'b0;
    check("hwm_after_reset", int'(hwm), 0);
    for (int i = 0; i < 3; i++) begin
      I_valid = 1'b1; I__0 = 5'(i + 20); I__1 = 1'b1;
      step();
    end
    I_valid = 1'b0;
    O_ready = 1'b1;
    repeat (3) step();
    O_ready = 1'b0;
    step();
    check("hwm_persist", int'(hwm), 3);
    check("hwm_count0", int'(count), 0);
    #2;
    ASYNCRESET = 1'b1;
    #1;
    check("hwm_cleared", int'(hwm), 0);
    step();
    ASYNCRESET = 1'b0;
`endif

    step();
    step();
    check("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
